if_stage: RTL and testbench

- Instruction-fetch stage with an IF/ID pipeline register, directly upstream of the main control decoder.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched word and presents opcode/func to the control decoder in ID.
- Applies next-PC redirection from the decoder's jump output and from resolved taken branches; supports stall, flush and a memory-wait handshake.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/if_stage_next_pc_sel.sv | 67 ++++++
 rtl/if_stage.sv | 86 ++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage, control decoder and ALU control.
// Holds opcode and ALUOp encodings, the bubble word and the next-PC source enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // sll $0,$0,0: decodes as a harmless R-type, so a bubble never hits decoder x outputs.
  localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    SEL_BRANCH = 3'd0,
    SEL_JUMP   = 3'd1,
    SEL_STALL  = 3'd2,
    SEL_WAIT   = 3'd3,
    SEL_SEQ    = 3'd4
  } pc_sel_e;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_next_pc_sel.sv
// Next-PC priority mux: picks the PC source for the coming edge and tells the
// fetch stage whether to load the PC and whether IF/ID loads, holds or bubbles.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4_id,
  input  logic [31:0] i_instr_id,
  input  logic        i_valid_id,
  input  logic        i_id_jump,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_stall,
  input  logic        i_imem_valid,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_pc_load,
  output logic        o_ifid_load,
  output logic        o_ifid_bubble
);

  pc_sel_e     w_sel;
  logic [31:0] w_jump_target;

  assign o_pc_plus4    = i_pc + 32'd4;
  assign w_jump_target = jump_target(i_pc_plus4_id, i_instr_id);

  // Redirects sit above stall: the instruction that raised the stall is being squashed.
  always_comb begin
    w_sel = SEL_SEQ;
    if (i_branch_taken)              w_sel = SEL_BRANCH;
    else if (i_id_jump && i_valid_id) w_sel = SEL_JUMP;
    else if (i_stall)                w_sel = SEL_STALL;
    else if (!i_imem_valid)          w_sel = SEL_WAIT;
  end

  always_comb begin
    o_next_pc     = o_pc_plus4;
    o_pc_load     = 1'b0;
    o_ifid_load   = 1'b0;
    o_ifid_bubble = 1'b0;
    case (w_sel)
      SEL_BRANCH: begin
        o_next_pc     = i_branch_target;
        o_pc_load     = 1'b1;
        o_ifid_bubble = 1'b1;
      end
      SEL_JUMP: begin
        o_next_pc     = w_jump_target;
        o_pc_load     = 1'b1;
        o_ifid_bubble = 1'b1;
      end
      SEL_STALL: begin
        o_next_pc = i_pc;
      end
      SEL_WAIT: begin
        o_next_pc     = i_pc;
        o_ifid_bubble = 1'b1;
      end
      default: begin
        o_pc_load   = 1'b1;
        o_ifid_load = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, feeds opcode/func
// to the control decoder and applies branch/jump redirects, stall and memory wait.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        id_jump,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] pc,
  output logic [31:0] instr_id,
  output logic [31:0] pc_plus4_id,
  output logic        valid_id,
  output logic [5:0]  opcode_id,
  output logic [5:0]  func_id
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;
  logic        w_pc_load;
  logic        w_ifid_load;
  logic        w_ifid_bubble;

  next_pc_sel u_next_pc_sel (
    .i_pc            (r_pc),
    .i_pc_plus4_id   (r_pc_plus4),
    .i_instr_id      (r_instr),
    .i_valid_id      (r_valid),
    .i_id_jump       (id_jump),
    .i_branch_taken  (ex_branch_taken),
    .i_branch_target (ex_branch_target),
    .i_stall         (stall),
    .i_imem_valid    (imem_valid),
    .o_next_pc       (w_next_pc),
    .o_pc_plus4      (w_pc_plus4),
    .o_pc_load       (w_pc_load),
    .o_ifid_load     (w_ifid_load),
    .o_ifid_bubble   (w_ifid_bubble)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_pc_load) begin
      r_pc <= w_next_pc;
    end
  end

  // A bubble keeps pc_plus4_id; only valid_id qualifies its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else if (w_ifid_bubble) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (w_ifid_load) begin
      r_instr    <= imem_rdata;
      r_pc_plus4 <= w_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr_id    = r_instr;
  assign pc_plus4_id = r_pc_plus4;
  assign valid_id    = r_valid;
  assign opcode_id   = r_instr[31:26];
  assign func_id     = r_instr[5:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, jump, branch priority, stall,
// memory wait, async reset and PC wrap, each with hand-computed expectations.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        id_jump;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [31:0] pc;
  logic [31:0] instr_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;
  logic [5:0]  opcode_id;
  logic [5:0]  func_id;

  logic        j_mode;
  int          n_total;
  int          n_bad;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_valid       (imem_valid),
    .stall            (stall),
    .id_jump          (id_jump),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .pc               (pc),
    .instr_id         (instr_id),
    .pc_plus4_id      (pc_plus4_id),
    .valid_id         (valid_id),
    .opcode_id        (opcode_id),
    .func_id          (func_id)
  );

  // Instruction memory: word = 32'hAC10_0000 | addr, except "j 0x40" at 4 in jump mode.
  assign imem_rdata = (j_mode && imem_addr == 32'h4) ? 32'h0800_0010
                                                     : (32'hAC10_0000 | imem_addr);

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_valid       = 1'b1;
    stall            = 1'b0;
    id_jump          = 1'b0;
    ex_branch_taken  = 1'b0;
    ex_branch_target = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    ex_branch_taken  = 1'b1;
    ex_branch_target = tgt;
    tick();
    ex_branch_taken  = 1'b0;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_pc,
                          input logic [31:0] e_instr, input logic e_valid);
    check({tag, "_pc"},    pc,        e_pc);
    check({tag, "_instr"}, instr_id,  e_instr);
    check({tag, "_valid"}, {31'b0, valid_id}, {31'b0, e_valid});
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    j_mode  = 1'b0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();

    // reset state
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst_pc4",    pc_plus4_id, 32'h0);
    check("rst_addr",   imem_addr,   32'h0);
    check("rst_opcode", {26'b0, opcode_id}, 32'h0);

    // sequential fetch A,B,C
    rst = 1'b0;
    tick();
    chk_ifid("seq0", 32'h4, 32'hAC10_0000, 1'b1);
    check("seq0_pc4",    pc_plus4_id, 32'h4);
    check("seq0_opcode", {26'b0, opcode_id}, 32'h2B);
    check("seq0_addr",   imem_addr, 32'h4);
    tick();
    chk_ifid("seq1", 32'h8, 32'hAC10_0004, 1'b1);
    check("seq1_pc4",  pc_plus4_id, 32'h8);
    check("seq1_func", {26'b0, func_id}, 32'h04);
    tick();
    chk_ifid("seq2", 32'hC, 32'hAC10_0008, 1'b1);
    check("seq2_pc4", pc_plus4_id, 32'hC);

    // jump: j 0x40 sits at address 4
    j_mode = 1'b1;
    do_reset();
    tick();
    tick();
    chk_ifid("jpre", 32'h8, 32'h0800_0010, 1'b1);
    check("jpre_pc4",    pc_plus4_id, 32'h8);
    check("jpre_opcode", {26'b0, opcode_id}, 32'h02);
    id_jump = 1'b1;
    tick();
    chk_ifid("jump", 32'h40, 32'h0, 1'b0);
    check("jump_opcode", {26'b0, opcode_id}, 32'h0);
    // id_jump still high but IF/ID is a bubble: no jump may be taken
    tick();
    chk_ifid("jgate", 32'h44, 32'hAC10_0040, 1'b1);
    check("jgate_pc4", pc_plus4_id, 32'h44);
    j_mode = 1'b0;

    // branch and jump (and stall) together: branch wins
    stall = 1'b1;
    branch_to(32'h100);
    id_jump = 1'b0;
    stall   = 1'b0;
    chk_ifid("brj", 32'h100, 32'h0, 1'b0);

    // stall 3 cycles at pc=0x20
    branch_to(32'h20);
    chk_ifid("st_pre", 32'h20, 32'h0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ifid($sformatf("st%0d", i), 32'h20, 32'h0, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk_ifid("st_rel", 32'h24, 32'hAC10_0020, 1'b1);
    check("st_rel_pc4", pc_plus4_id, 32'h24);
    stall = 1'b1;
    tick();
    chk_ifid("st_hold", 32'h24, 32'hAC10_0020, 1'b1);
    stall = 1'b0;

    // memory wait at pc=0x10; the redirect itself ignores imem_valid
    imem_valid = 1'b0;
    branch_to(32'h10);
    chk_ifid("w_pre", 32'h10, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_ifid($sformatf("w%0d", i), 32'h10, 32'h0, 1'b0);
      check($sformatf("w%0d_pc4", i), pc_plus4_id, 32'h24);
    end
    imem_valid = 1'b1;
    tick();
    chk_ifid("w_rel", 32'h14, 32'hAC10_0010, 1'b1);
    check("w_rel_pc4", pc_plus4_id, 32'h14);

    // async reset mid-cycle at pc=0x40, during a stall
    branch_to(32'h3C);
    tick();
    chk_ifid("ar_pre", 32'h40, 32'hAC10_003C, 1'b1);
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_ifid("ar", 32'h0, 32'h0, 1'b0);
    check("ar_pc4", pc_plus4_id, 32'h0);
    tick();
    rst   = 1'b0;
    stall = 1'b0;

    // PC wrap
    branch_to(32'hFFFF_FFFC);
    tick();
    chk_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1);
    check("wrap_pc4", pc_plus4_id, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
